qspi_ram_arbiter: RTL
=====================

Name: qspi_ram_arbiter

Overview:
Shares the single QSPI serial SRAM controller port between two requesters: the display framebuffer fetcher (read-only, latency-critical) and the Hack CPU data port (read/write). It sits inside hack_soc between both requesters and the QSPI SRAM controller. It grants one transaction at a time. Display has fixed priority, and a starvation guard guarantees the CPU forward progress.

Parameters:
ADDR_WIDTH, 16, word address width on all ports
DATA_WIDTH, 16, data word width
MAX_DISP_BURST, 4, consecutive display grants allowed while cpu_req is pending before the CPU is forced a grant (range 1..255)
TIMEOUT_CYCLES, 1023, mem_ack watchdog limit (only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  single system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
disp_req  input  1  display read request, level, held until disp_ack
disp_addr  input  ADDR_WIDTH  display read address, stable while disp_req high
disp_rdata  output  DATA_WIDTH  read data, valid in disp_ack cycle and held until next display completion
disp_ack  output  1  one-cycle completion pulse
cpu_req  input  1  CPU request, level, held until cpu_ack
cpu_we  input  1  1=write, 0=read
cpu_addr  input  ADDR_WIDTH  CPU address
cpu_wdata  input  DATA_WIDTH  CPU write data
cpu_rdata  output  DATA_WIDTH  CPU read data, valid in cpu_ack cycle and held
cpu_ack  output  1  one-cycle completion pulse
mem_req  output  1  request to QSPI controller, held until mem_ack
mem_we  output  1  write enable to controller
mem_addr  output  ADDR_WIDTH  address to controller
mem_wdata  output  DATA_WIDTH  write data to controller
mem_rdata  input  DATA_WIDTH  read data from controller, valid with mem_ack
mem_ack  input  1  one-cycle done pulse from controller
err  output  1  sticky timeout flag (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset (synchronous, highest priority, also mid-transaction) forces all outputs to 0. State goes to IDLE. The burst counter is cleared. An in-flight transaction is abandoned, and the QSPI controller shares the same reset.
- States: IDLE, BUSY_DISP, BUSY_CPU, DONE.
- IDLE, arbitration in cycle N:
  - Display wins if disp_req=1, unless cpu_req=1 and burst_cnt==MAX_DISP_BURST; then the CPU wins.
  - The CPU wins if only cpu_req=1.
  - With no request, stay in IDLE.
- Winner's addr/we/wdata are registered at N. mem_req=1 from N+1. Display grants always drive mem_we=0 and mem_wdata=0.
- burst_cnt:
  - Increments (saturating at MAX_DISP_BURST) on each display grant made while cpu_req=1.
  - Clears on a CPU grant, or in any IDLE cycle where cpu_req=0.
- BUSY_x: mem_req, mem_we, mem_addr and mem_wdata are held constant. On mem_ack in cycle M:
  - mem_rdata is latched into the granted requester's rdata.
  - mem_req drops at M+1.
  - State goes to DONE.
- DONE (cycle M+1): the granted requester's ack=1 for exactly this cycle. The next state is IDLE (M+2).
- Requesters must deassert req by M+2. A req still high at M+2 is a new request.
- Minimum turnaround is 4 cycles per transaction plus controller latency (N grant, N+1 mem_req, M ack, M+1 ack out).
- A requester dropping req while granted does not abort. The transaction completes and ack still pulses.
- mem_ack seen in IDLE or DONE is ignored.
- Only one of disp_ack or cpu_ack is ever high, and never both.
- Non-granted rdata holds its previous value.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: a counter runs in BUSY_x. If TIMEOUT_CYCLES cycles pass without mem_ack:
  - mem_req drops.
  - The granted rdata is set to all-ones.
  - State goes to DONE, and the requester's ack pulses normally.
  - err is set and stays set until reset.
- Not defined: no counter. BUSY_x waits indefinitely for mem_ack and err is constant 0.

Test Plan:
- Reset, then cpu read: cpu_req=1, cpu_we=0, cpu_addr=0x0010; model acks after 6 cycles with 0xBEEF -> mem_req=1 one cycle after the grant, mem_we=0, mem_addr=0x0010; cpu_ack is a single pulse one cycle after mem_ack; cpu_rdata=0xBEEF.
- Simultaneous disp_req (addr 0x4000) and cpu_req (write 0x1234 to 0x0020) in the same cycle -> the display is served first; the CPU write follows with mem_we=1 and mem_wdata=0x1234; disp_ack precedes cpu_ack.
- Display held continuously high, cpu_req high, MAX_DISP_BURST=4 -> grant order D,D,D,D,C,D,D,D,D,C.
- Reset asserted while BUSY_CPU, 2 cycles before mem_ack -> the next cycle has all outputs 0 and no cpu_ack; a late mem_ack after reset is ignored.
- Requester drops cpu_req mid-transaction -> the transaction completes and cpu_ack still pulses once.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the model never acks a display read -> mem_req drops after 8 busy cycles; disp_rdata=0xFFFF; disp_ack pulses; err=1 stays set until reset.

Source files
------------

// File: rtl/qspi_ram_arbiter.sv
// qspi_ram_arbiter: display-priority arbiter with CPU starvation guard sharing one QSPI SRAM port.
// Optional mem_ack watchdog enabled by defining ARB_TIMEOUT_EN.
module qspi_ram_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_DISP_BURST = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_rdata,
  output logic                  disp_ack,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, BUSY_DISP, BUSY_CPU, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] burst_cnt;
  logic disp_win, cpu_win, busy, done_now, tmo;
  logic [DATA_WIDTH-1:0] rd;
  always_comb begin
    busy     = state == BUSY_DISP || state == BUSY_CPU;
    disp_win = state == IDLE && disp_req && !(cpu_req && burst_cnt == 8'(MAX_DISP_BURST));
    cpu_win  = state == IDLE && cpu_req && !disp_win;
    done_now = busy && (mem_ack || tmo);
    rd       = mem_ack ? mem_rdata : '1;
    state_nx = disp_win ? BUSY_DISP :
               cpu_win  ? BUSY_CPU  :
               done_now ? DONE      :
               state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      disp_rdata <= '0;
      cpu_rdata  <= '0;
      disp_ack   <= 1'b0;
      cpu_ack    <= 1'b0;
    end else begin
      state    <= state_nx;
      disp_ack <= done_now && state == BUSY_DISP;
      cpu_ack  <= done_now && state == BUSY_CPU;
      if (disp_win || cpu_win) begin
        mem_req   <= 1'b1;
        mem_we    <= cpu_win && cpu_we;
        mem_addr  <= disp_win ? disp_addr : cpu_addr;
        mem_wdata <= cpu_win ? cpu_wdata : '0;
      end
      if (done_now) mem_req <= 1'b0;
      if (done_now && state == BUSY_DISP) disp_rdata <= rd;
      if (done_now && state == BUSY_CPU) cpu_rdata <= rd;
      burst_cnt <= (cpu_win || (state == IDLE && !cpu_req)) ? 8'd0 :
                   (disp_win && burst_cnt != 8'(MAX_DISP_BURST)) ? burst_cnt + 8'd1 : burst_cnt;
    end
  end
`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr;
  assign tmo = busy && !mem_ack && tmr == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    tmr <= (reset || !busy) ? '0 : tmr + 1'b1;
    err <= reset ? 1'b0 : (err || tmo);
  end
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
endmodule
